// File: rtl/rgb_fade_sequencer_if.sv
// Preset-load handshake between a configuration master and the RGB fade sequencer.
// The master holds load_valid until load_ready is seen on the same edge.
interface rgb_fade_sequencer_if;
    logic        load_valid;
    logic        load_ready;
    logic [1:0]  load_idx;
    logic [23:0] load_rgb;

    modport master (output load_valid, load_idx, load_rgb, input load_ready);
    modport slave  (input load_valid, load_idx, load_rgb, output load_ready);
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Four-preset RGB sequencer: holds each preset for HOLD_TICKS ticks, then fades
// linearly (one LSB per channel per tick) to the next preset, cycling 0->1->2->3->0.
module rgb_fade_sequencer #(
    parameter int unsigned PRESCALE   = 256,
    parameter int unsigned HOLD_TICKS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    rgb_fade_sequencer_if.slave  load,
    output logic [7:0]           duty0,
    output logic [7:0]           duty1,
    output logic [7:0]           duty2,
    output logic [1:0]           cur_idx,
    output logic                 seg_done,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, HOLD, FADE} state_e;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_TICKS - 1);

    state_e      state_q;
    logic [23:0] preset_q [4];
    logic [23:0] target_q;
    logic [15:0] presc_q;
    logic [15:0] hold_q;
    logic [7:0]  duty0_q, duty1_q, duty2_q;
    logic [7:0]  duty0_d, duty1_d, duty2_d;
    logic [1:0]  cur_idx_q;
    logic        seg_done_q;
    logic        busy_q;
    logic        load_ready_q;
    logic        tick;
    logic        match;

    function automatic logic [7:0] step8(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        match   = ({duty0_q, duty1_q, duty2_q} == target_q);
        duty0_d = step8(duty0_q, target_q[23:16]);
        duty1_d = step8(duty1_q, target_q[15:8]);
        duty2_d = step8(duty2_q, target_q[7:0]);
    end

    // Preset reads below see the pre-edge array, so a write on a sampling edge lands afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            preset_q     <= '{default: '0};
            target_q     <= '0;
            presc_q      <= '0;
            hold_q       <= '0;
            duty0_q      <= '0;
            duty1_q      <= '0;
            duty2_q      <= '0;
            cur_idx_q    <= '0;
            seg_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            seg_done_q <= 1'b0;
            if (load.load_valid && load_ready_q) begin
                preset_q[load.load_idx] <= load.load_rgb;
            end

            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q                     <= HOLD;
                        {duty0_q, duty1_q, duty2_q} <= preset_q[cur_idx_q];
                        hold_q                      <= '0;
                        presc_q                     <= '0;
                        busy_q                      <= 1'b1;
                        load_ready_q                <= 1'b1;
                    end
                end

                HOLD: begin
                    if (!run) begin
                        state_q      <= IDLE;
                        presc_q      <= '0;
                        hold_q       <= '0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                    end else if (tick) begin
                        presc_q <= '0;
                        hold_q  <= hold_q + 16'd1;
                        if (hold_q == HOLD_LAST) begin
                            state_q      <= FADE;
                            target_q     <= preset_q[cur_idx_q + 2'd1];
                            load_ready_q <= 1'b0;
                        end
                    end else begin
                        presc_q <= presc_q + 16'd1;
                    end
                end

                FADE: begin
                    if (!run) begin
                        state_q      <= IDLE;
                        presc_q      <= '0;
                        hold_q       <= '0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                    end else if (match) begin
                        state_q      <= HOLD;
                        cur_idx_q    <= cur_idx_q + 2'd1;
                        seg_done_q   <= 1'b1;
                        hold_q       <= '0;
                        presc_q      <= '0;
                        load_ready_q <= 1'b1;
                    end else if (tick) begin
                        duty0_q <= duty0_d;
                        duty1_q <= duty1_d;
                        duty2_q <= duty2_d;
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + 16'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign load.load_ready = load_ready_q;
    assign duty0           = duty0_q;
    assign duty1           = duty1_q;
    assign duty2           = duty2_q;
    assign cur_idx         = cur_idx_q;
    assign seg_done        = seg_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with PRESCALE=4, HOLD_TICKS=2: a step table
// of {inputs, cycles, expected outputs} plus hand-written wrap/edge-write sequences.
module tb_rgb_fade_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] duty0, duty1, duty2;
    logic [1:0] cur_idx;
    logic       seg_done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_fade_sequencer_if lif ();

    rgb_fade_sequencer #(.PRESCALE(4), .HOLD_TICKS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .load     (lif),
        .duty0    (duty0),
        .duty1    (duty1),
        .duty2    (duty2),
        .cur_idx  (cur_idx),
        .seg_done (seg_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        rst;
        logic        run;
        logic        lv;
        logic [1:0]  li;
        logic [23:0] rgb;
        logic [23:0] exp_duty;
        logic [1:0]  exp_cur;
        logic        exp_busy;
        logic        exp_rdy;
        logic        exp_seg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic rst, logic rn, logic lv, logic [1:0] li,
                                logic [23:0] rgb, logic [23:0] d, logic [1:0] c,
                                logic b, logic r, logic s);
        vec_t v;
        v.n = n; v.rst = rst; v.run = rn; v.lv = lv; v.li = li; v.rgb = rgb;
        v.exp_duty = d; v.exp_cur = c; v.exp_busy = b; v.exp_rdy = r; v.exp_seg = s;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_preset(input logic [1:0] idx, input logic [23:0] rgb);
        lif.load_valid = 1'b1;
        lif.load_idx   = idx;
        lif.load_rgb   = rgb;
        cyc();
        lif.load_valid = 1'b0;
    endtask

    task automatic wait_seg(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!seg_done && n < limit);
    endtask

    initial begin
        int n;

        reset          = 1'b1;
        run            = 1'b1;
        lif.load_valid = 1'b0;
        lif.load_idx   = '0;
        lif.load_rgb   = '0;

        //   n rst run lv idx rgb        duty       cur busy rdy seg
        add(2, 1, 1, 0, 0, 24'h000000, 24'h000000, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 24'h102030, 24'h000000, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 24'h131E30, 24'h000000, 0, 0, 1, 0);
        add(1, 0, 0, 1, 2, 24'h141F31, 24'h000000, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h102030, 0, 1, 1, 0);
        add(7, 0, 1, 0, 0, 24'h000000, 24'h102030, 0, 1, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h102030, 0, 1, 0, 0);
        add(3, 0, 1, 0, 0, 24'h000000, 24'h102030, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h111F30, 0, 1, 0, 0);
        add(4, 0, 1, 0, 0, 24'h000000, 24'h121E30, 0, 1, 0, 0);
        add(4, 0, 1, 0, 0, 24'h000000, 24'h131E30, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h131E30, 1, 1, 1, 1);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h131E30, 1, 1, 1, 0);
        add(6, 0, 1, 0, 0, 24'h000000, 24'h131E30, 1, 1, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h131E30, 1, 1, 0, 0);
        // backpressure: slot-3 write held through the 1->2 fade
        add(3, 0, 1, 1, 3, 24'h141F31, 24'h131E30, 1, 1, 0, 0);
        add(1, 0, 1, 1, 3, 24'h141F31, 24'h141F31, 1, 1, 0, 0);
        add(1, 0, 1, 1, 3, 24'h141F31, 24'h141F31, 2, 1, 1, 1);
        add(1, 0, 1, 1, 3, 24'h141F31, 24'h141F31, 2, 1, 1, 0);
        add(6, 0, 1, 0, 0, 24'h000000, 24'h141F31, 2, 1, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h141F31, 2, 1, 0, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h141F31, 3, 1, 1, 1);
        add(7, 0, 1, 0, 0, 24'h000000, 24'h141F31, 3, 1, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h141F31, 3, 1, 0, 0);
        add(8, 0, 1, 0, 0, 24'h000000, 24'h122030, 3, 1, 0, 0);
        // freeze mid-fade, then reload preset 3
        add(1, 0, 0, 0, 0, 24'h000000, 24'h122030, 3, 0, 1, 0);
        add(3, 0, 0, 0, 0, 24'h000000, 24'h122030, 3, 0, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h141F31, 3, 1, 1, 0);
        add(7, 0, 1, 0, 0, 24'h000000, 24'h141F31, 3, 1, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h141F31, 3, 1, 0, 0);
        add(4, 0, 1, 0, 0, 24'h000000, 24'h132030, 3, 1, 0, 0);
        // reset mid-fade, then sequence all-zero presets
        add(1, 1, 1, 0, 0, 24'h000000, 24'h000000, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h000000, 0, 1, 1, 0);
        add(7, 0, 1, 0, 0, 24'h000000, 24'h000000, 0, 1, 1, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h000000, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h000000, 1, 1, 1, 1);
        add(1, 0, 1, 0, 0, 24'h000000, 24'h000000, 1, 1, 1, 0);

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            run            = vecs[i].run;
            lif.load_valid = vecs[i].lv;
            lif.load_idx   = vecs[i].li;
            lif.load_rgb   = vecs[i].rgb;
            repeat (vecs[i].n) cyc();
            chk($sformatf("v%0d_duty", i), {8'h0, duty0, duty1, duty2}, {8'h0, vecs[i].exp_duty});
            chk($sformatf("v%0d_cur", i), 32'(cur_idx), 32'(vecs[i].exp_cur));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_ready", i), 32'(lif.load_ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_seg", i), 32'(seg_done), 32'(vecs[i].exp_seg));
        end

        // write on the HOLD->FADE edge, then wrap through equal presets
        reset          = 1'b1;
        run            = 1'b0;
        lif.load_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        load_preset(2'd0, 24'h555555);
        load_preset(2'd1, 24'h565555);
        load_preset(2'd2, 24'h555555);
        load_preset(2'd3, 24'h555555);
        run = 1'b1;
        cyc();
        chk("hs_start_duty", {8'h0, duty0, duty1, duty2}, 32'h00555555);
        repeat (7) cyc();
        lif.load_valid = 1'b1;
        lif.load_idx   = 2'd1;
        lif.load_rgb   = 24'h000000;
        cyc();
        lif.load_valid = 1'b0;
        chk("hs_edge_fade_ready", 32'(lif.load_ready), 32'd0);
        repeat (4) cyc();
        chk("hs_edge_target_old", {8'h0, duty0, duty1, duty2}, 32'h00565555);
        cyc();
        chk("hs_seg1", 32'(seg_done), 32'd1);
        chk("hs_cur1", 32'(cur_idx), 32'd1);
        wait_seg(40, n);
        chk("hs_len_1to2", 32'(n), 32'd13);
        chk("hs_cur2", 32'(cur_idx), 32'd2);
        wait_seg(40, n);
        chk("hs_len_2to3", 32'(n), 32'd9);
        chk("hs_cur3", 32'(cur_idx), 32'd3);
        wait_seg(40, n);
        chk("hs_len_3to0", 32'(n), 32'd9);
        chk("hs_wrap_cur", 32'(cur_idx), 32'd0);
        chk("hs_wrap_duty", {8'h0, duty0, duty1, duty2}, 32'h00555555);
        cyc();
        chk("hs_seg_one_cycle", 32'(seg_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
